control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 32 +++
 rtl/reg_decoder_4to16.sv | 11 +
 rtl/control_sequencer.sv | 130 +++++++++++++
 tb/tb_control_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared CPU definitions for the control sequencer: state encoding,
// multiply/divide opcodes and IR field bit positions.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_t;

    localparam logic [4:0] OPC_MUL = 5'b01110;
    localparam logic [4:0] OPC_DIV = 5'b01111;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    function automatic logic is_muldiv(input logic [4:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// Register-select decoder: 4-bit register index to a 16-bit one-hot
// strobe vector, all zero when not enabled.
module reg_decoder_4to16 (
    input  logic        en,
    input  logic [3:0]  idx,
    output logic [15:0] onehot
);

    assign onehot = en ? (16'h0001 << idx) : 16'h0000;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer for MUL and DIV: walks T0..T6 once per
// start request and decodes datapath strobes from the registered state and IR.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        MUL,
    output logic        DIV,
    output logic        LOin,
    output logic        HIin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_t      state;
    logic [4:0]  opcode;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        op_ok;
    logic        rout_en;
    logic [3:0]  rout_idx;
    logic        unused_ir_bits;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign rb     = ir[RB_MSB:RB_LSB];
    assign rc     = ir[RC_MSB:RC_LSB];
    assign op_ok  = is_muldiv(opcode);

    // Ra and the immediate bits are not consumed by MUL/DIV sequencing.
    assign unused_ir_bits = ^{ir[RA_MSB:RA_LSB], ir[RC_LSB-1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3:    state <= op_ok ? S_T4 : S_IDLE;
                S_T4:    state <= S_T5;
                S_T5:    state <= S_T6;
                S_T6:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
         MDRin, MDRout, IRin, Yin, MUL, DIV, LOin, HIin} = '0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        illegal  = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rc;
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Yin      = op_ok;
                rout_en  = op_ok;
                rout_idx = rb;
                illegal  = !op_ok;
            end
            S_T4: begin
                Zin     = 1'b1;
                MUL     = (opcode == OPC_MUL);
                DIV     = (opcode == OPC_DIV);
                rout_en = 1'b1;
            end
            S_T5: begin
                Zlowout = 1'b1;
                LOin    = 1'b1;
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_decoder_4to16 u_rout_dec (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (Rout)
    );

    assign Rin = 16'h0000;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each accepted instruction expands into a queue of
// expected per-cycle output records that is compared against the DUT.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] strb;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        busy;
        logic        done;
        logic        illegal;
    } obs_t;

    localparam logic [15:0] M_PCOUT    = 16'h8000;
    localparam logic [15:0] M_MARIN    = 16'h4000;
    localparam logic [15:0] M_INCPC    = 16'h2000;
    localparam logic [15:0] M_ZIN      = 16'h1000;
    localparam logic [15:0] M_ZLOWOUT  = 16'h0800;
    localparam logic [15:0] M_ZHIGHOUT = 16'h0400;
    localparam logic [15:0] M_PCIN     = 16'h0200;
    localparam logic [15:0] M_READ     = 16'h0100;
    localparam logic [15:0] M_MDRIN    = 16'h0080;
    localparam logic [15:0] M_MDROUT   = 16'h0040;
    localparam logic [15:0] M_IRIN     = 16'h0020;
    localparam logic [15:0] M_YIN      = 16'h0010;
    localparam logic [15:0] M_MUL      = 16'h0008;
    localparam logic [15:0] M_DIV      = 16'h0004;
    localparam logic [15:0] M_LOIN     = 16'h0002;
    localparam logic [15:0] M_HIIN     = 16'h0001;

    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ir = 32'h0;

    logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
    logic MDRin, MDRout, IRin, Yin, MUL, DIV, LOin, HIin;
    logic [15:0] Rout, Rin;
    logic busy, done, illegal;

    control_sequencer dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .ir       (ir),
        .PCout    (PCout),
        .MARin    (MARin),
        .IncPC    (IncPC),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .PCin     (PCin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .MUL      (MUL),
        .DIV      (DIV),
        .LOin     (LOin),
        .HIin     (HIin),
        .Rout     (Rout),
        .Rin      (Rin),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    obs_t obs;
    assign obs.strb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
                       MDRin, MDRout, IRin, Yin, MUL, DIV, LOin, HIin};
    assign obs.rout    = Rout;
    assign obs.rin     = Rin;
    assign obs.busy    = busy;
    assign obs.done    = done;
    assign obs.illegal = illegal;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t rec(input logic [15:0] strb, input logic [15:0] rout,
                                 input logic dn, input logic ill);
        obs_t r;
        r = '0;
        r.strb    = strb;
        r.rout    = rout;
        r.busy    = 1'b1;
        r.done    = dn;
        r.illegal = ill;
        return r;
    endfunction

    // Expand one accepted instruction into its cycle-by-cycle output records.
    task automatic enqueue(input logic [31:0] word);
        logic [4:0] opc;
        logic [3:0] rb, rc;
        opc = word[31:27];
        rb  = word[22:19];
        rc  = word[18:15];
        exp_q.push_back(rec(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 16'h0, 1'b0, 1'b0));
        exp_q.push_back(rec(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 16'h0, 1'b0, 1'b0));
        exp_q.push_back(rec(M_MDROUT | M_IRIN, 16'h0, 1'b0, 1'b0));
        if (opc == OP_MUL || opc == OP_DIV) begin
            exp_q.push_back(rec(M_YIN, 16'h0001 << rb, 1'b0, 1'b0));
            exp_q.push_back(rec(M_ZIN | ((opc == OP_MUL) ? M_MUL : M_DIV),
                                16'h0001 << rc, 1'b0, 1'b0));
            exp_q.push_back(rec(M_ZLOWOUT | M_LOIN, 16'h0, 1'b0, 1'b0));
            exp_q.push_back(rec(M_ZHIGHOUT | M_HIIN, 16'h0, 1'b1, 1'b0));
        end else begin
            exp_q.push_back(rec(16'h0, 16'h0, 1'b0, 1'b1));
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    // One clock: advance the model at the edge, then compare at the falling edge.
    task automatic tick(input string tag);
        obs_t e;
        @(posedge clk);
        if (clr) exp_q.delete();
        else if (exp_q.size() != 0) e = exp_q.pop_front();
        else if (start) enqueue(ir);
        @(negedge clk);
        e = (exp_q.size() != 0) ? exp_q[0] : obs_t'('0);
        check(tag, 64'(obs), 64'(e));
        check({tag, "_rout_onehot"}, 64'($countones(Rout) <= 1), 64'd1);
        check({tag, "_bus_single"},
              64'($countones({PCout, Zlowout, Zhighout, MDRout, |Rout}) <= 1), 64'd1);
    endtask

    initial begin
        int lat;
        int cnt;
        logic [31:0] r;
        logic [4:0]  opc;

        // Reset
        clr = 1'b1;
        tick("reset0");
        tick("reset1");
        clr = 1'b0;
        tick("idle0");
        tick("idle1");

        // MUL Ra=2 Rb=3 Rc=0, 7-cycle latency
        ir = 32'h71180000;
        start = 1'b1;
        tick("mul");
        start = 1'b0;
        lat = 0;
        for (int i = 2; i <= 10; i++) begin
            tick("mul");
            if (done && lat == 0) lat = i;
        end
        check("mul_latency", 64'(lat), 64'd7);

        // DIV Rb=6 Rc=3, with a start pulse during T2 that must be ignored
        ir = 32'h7A318000;
        start = 1'b1;
        tick("div_t0");
        start = 1'b0;
        tick("div_t1");
        start = 1'b1;
        tick("div_t2");
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick("div");

        // Illegal opcode 00101: pulse in cycle 4, never done
        ir = 32'h28918000;
        start = 1'b1;
        tick("ill");
        start = 1'b0;
        lat = 0;
        cnt = 0;
        for (int i = 2; i <= 8; i++) begin
            tick("ill");
            if (illegal && lat == 0) lat = i;
            if (done) cnt++;
        end
        check("ill_latency", 64'(lat), 64'd4);
        check("ill_no_done", 64'(cnt), 64'd0);

        // Clear in T4, then a clean full run
        ir = 32'h71180000;
        start = 1'b1;
        tick("clr_t0");
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick("clr_pre");
        check("clr_in_t4", 64'(MUL), 64'd1);
        clr = 1'b1;
        start = 1'b1;
        tick("clr_mid");
        clr = 1'b0;
        tick("clr_after");
        start = 1'b0;
        lat = 0;
        for (int i = 2; i <= 10; i++) begin
            tick("clr_rerun");
            if (done && lat == 0) lat = i;
        end
        check("clr_rerun_latency", 64'(lat), 64'd7);

        // start held high: one instruction every 8 cycles
        ir = 32'h7A318000;
        start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick("b2b");
            if (done) cnt++;
        end
        check("b2b_done_count", 64'(cnt), 64'd3);
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick("b2b_drain");

        // Randomized traffic; IR only changes while the model is idle
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) begin
                r = $urandom();
                case ($urandom_range(0, 3))
                    0:       opc = OP_MUL;
                    1:       opc = OP_DIV;
                    default: opc = 5'($urandom_range(0, 31));
                endcase
                ir = {opc, r[26:0]};
            end
            start = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 39) == 0);
            tick("rand");
        end
        clr = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
